// File: rtl/mest_pkg.sv
// Shared types for the mest result-side logic: collector FSM states,
// the packed capture entry layout and default sizing.
package mest_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } collector_state_t;

    typedef struct packed {
        logic                      carry;
        logic                      zero;
        logic [DEF_DATA_WIDTH-1:0] result;
    } result_entry_t;

endpackage

// File: rtl/mest_result_fifo.sv
// Capture buffer: circular storage with write/read pointers and an entry count.
// Ports: i_clear (restart, a same-cycle write becomes entry 0), i_wr_en/i_wr_data,
// i_rd_en -> o_rd_valid/o_rd_data one cycle later, o_count, o_full.
module mest_result_fifo #(
    parameter int WIDTH     = 10,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_wr_en,
    input  logic [WIDTH-1:0]     i_wr_data,
    input  logic                 i_rd_en,
    output logic                 o_rd_valid,
    output logic [WIDTH-1:0]     o_rd_data,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_full
);
    import mest_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign o_full = (o_count == CNT_WIDTH'(DEPTH));
    assign do_wr  = i_wr_en && (i_clear || !o_full);
    assign do_rd  = i_rd_en && !i_clear && (o_count != '0);

    // a write during clear lands at slot 0, since the pointers restart there
    always_ff @(posedge clk) begin
        if (do_wr && !i_reset)
            mem[i_clear ? '0 : wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            o_rd_valid <= do_rd;
            if (do_rd)
                o_rd_data <= mem[rd_ptr];
            if (i_clear) begin
                wr_ptr  <= do_wr ? PTR_W'(1) : '0;
                rd_ptr  <= '0;
                o_count <= do_wr ? CNT_WIDTH'(1) : '0;
            end else begin
                if (do_wr)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (do_rd)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                if (do_wr && !do_rd)
                    o_count <= o_count + CNT_WIDTH'(1);
                else if (do_rd && !do_wr)
                    o_count <= o_count - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/mest_result_collector.sv
// Captures mest_pro results+flags into a buffer, tracks checksum/overflow,
// and lets a host drain entries after completion. Ports: i_arm starts a session,
// i_result/i_valid_result/i_carry/i_zero_flag/i_all_done from the processor,
// i_rd_en -> o_rd_valid/o_rd_data, status o_count/o_checksum/o_overflow/o_capturing/o_done.
module mest_result_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_arm,
    input  logic [DATA_WIDTH-1:0] i_result,
    input  logic                  i_valid_result,
    input  logic                  i_carry,
    input  logic                  i_zero_flag,
    input  logic                  i_all_done,
    input  logic                  i_rd_en,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH+1:0] o_rd_data,
    output logic [CNT_WIDTH-1:0]  o_count,
    output logic [DATA_WIDTH-1:0] o_checksum,
    output logic                  o_overflow,
    output logic                  o_capturing,
    output logic                  o_done
);
    import mest_pkg::*;

    collector_state_t state_q;
    collector_state_t state_d;
    logic             full;
    logic             cap_valid;
    logic             wr_en;
    logic             rd_en;

    assign o_capturing = (state_q == CAPTURE);
    assign o_done      = (state_q == DONE);

    assign cap_valid = o_capturing && i_valid_result;
    // arm empties the buffer first, so a same-cycle result always fits
    assign wr_en     = cap_valid && (i_arm || !full);
    assign rd_en     = o_done && i_rd_en && !i_arm;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_arm) state_d = CAPTURE;
            CAPTURE: if (!i_arm && i_all_done) state_d = DONE;
            DONE:    if (i_arm) state_d = CAPTURE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_checksum <= '0;
            o_overflow <= 1'b0;
        end else if (i_arm) begin
            o_checksum <= cap_valid ? i_result : '0;
            o_overflow <= 1'b0;
        end else if (cap_valid) begin
            if (full)
                o_overflow <= 1'b1;
            else
                o_checksum <= o_checksum + i_result;
        end
    end

    mest_result_fifo #(
        .WIDTH    (DATA_WIDTH + 2),
        .DEPTH    (DEPTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_clear   (i_arm),
        .i_wr_en   (wr_en),
        .i_wr_data ({i_carry, i_zero_flag, i_result}),
        .i_rd_en   (rd_en),
        .o_rd_valid(o_rd_valid),
        .o_rd_data (o_rd_data),
        .o_count   (o_count),
        .o_full    (full)
    );

endmodule

// File: tb/tb_mest_result_collector.sv
// Self-checking bench for mest_result_collector: directed vector table
// followed by randomized traffic against a queue-based reference model.
module tb_mest_result_collector;
    import mest_pkg::*;

    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_arm = 1'b0;
    logic [7:0] i_result = '0;
    logic       i_valid_result = 1'b0;
    logic       i_carry = 1'b0;
    logic       i_zero_flag = 1'b0;
    logic       i_all_done = 1'b0;
    logic       i_rd_en = 1'b0;
    logic       o_rd_valid;
    logic [9:0] o_rd_data;
    logic [4:0] o_count;
    logic [7:0] o_checksum;
    logic       o_overflow;
    logic       o_capturing;
    logic       o_done;

    int checks = 0;
    int errors = 0;

    mest_result_collector dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_arm         (i_arm),
        .i_result      (i_result),
        .i_valid_result(i_valid_result),
        .i_carry       (i_carry),
        .i_zero_flag   (i_zero_flag),
        .i_all_done    (i_all_done),
        .i_rd_en       (i_rd_en),
        .o_rd_valid    (o_rd_valid),
        .o_rd_data     (o_rd_data),
        .o_count       (o_count),
        .o_checksum    (o_checksum),
        .o_overflow    (o_overflow),
        .o_capturing   (o_capturing),
        .o_done        (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, arm, vld;
        logic [7:0] res;
        logic       c, z, dn, rd;
        logic [4:0] cnt;
        logic [7:0] cks;
        logic       ovf, cap, dne, rv;
        logic [9:0] rdat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic rst, arm, vld, input logic [7:0] res,
        input logic c, z, dn, rd, input logic [4:0] cnt,
        input logic [7:0] cks, input logic ovf, cap, dne, rv,
        input logic [9:0] rdat);
        vec_t r;
        r.rst = rst; r.arm = arm; r.vld = vld; r.res = res;
        r.c = c; r.z = z; r.dn = dn; r.rd = rd;
        r.cnt = cnt; r.cks = cks; r.ovf = ovf; r.cap = cap;
        r.dne = dne; r.rv = rv; r.rdat = rdat;
        return r;
    endfunction

    function automatic logic [9:0] ent(input logic c, z, input logic [7:0] r);
        result_entry_t e;
        e.carry = c; e.zero = z; e.result = r;
        return e;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, arm, vld, input logic [7:0] res,
                         input logic c, z, dn, rd);
        i_reset = rst; i_arm = arm; i_valid_result = vld; i_result = res;
        i_carry = c; i_zero_flag = z; i_all_done = dn; i_rd_en = rd;
        @(posedge clk);
        #1;
    endtask

    // reference model state
    logic [9:0] m_q[$];
    logic [7:0] m_cks;
    logic       m_ovf, m_cap, m_dne, m_rv;
    logic [9:0] m_rdat;

    task automatic model_step(input logic rst, arm, vld, input logic [7:0] res,
                              input logic c, z, dn, rd);
        m_rv = 1'b0;
        if (rst) begin
            m_q.delete(); m_cks = 0; m_ovf = 0;
            m_cap = 0; m_dne = 0; m_rdat = 0;
        end else if (arm) begin
            m_q.delete(); m_cks = 0; m_ovf = 0;
            if (m_cap && vld) begin
                m_q.push_back(ent(c, z, res));
                m_cks = res;
            end
            m_cap = 1; m_dne = 0;
        end else if (m_cap) begin
            if (vld) begin
                if (m_q.size() < 16) begin
                    m_q.push_back(ent(c, z, res));
                    m_cks = m_cks + res;
                end else begin
                    m_ovf = 1;
                end
            end
            if (dn) begin
                m_cap = 0; m_dne = 1;
            end
        end else if (m_dne) begin
            if (rd && m_q.size() > 0) begin
                m_rdat = m_q.pop_front();
                m_rv = 1;
            end
        end
    endtask

    initial begin
        int sum;
        // reset then idle
        vecs.push_back(v(1,0,0,8'h00,0,0,0,0, 0,8'h00,0,0,0,0,0));
        vecs.push_back(v(1,0,0,8'h00,0,0,0,0, 0,8'h00,0,0,0,0,0));
        vecs.push_back(v(0,0,1,8'h55,0,0,0,0, 0,8'h00,0,0,0,0,0));
        vecs.push_back(v(0,0,0,8'h00,0,0,1,0, 0,8'h00,0,0,0,0,0));
        vecs.push_back(v(0,0,0,8'h00,0,0,0,1, 0,8'h00,0,0,0,0,0));
        // basic capture and drain
        vecs.push_back(v(0,1,0,8'h00,0,0,0,0, 0,8'h00,0,1,0,0,0));
        vecs.push_back(v(0,0,1,8'h10,0,0,0,0, 1,8'h10,0,1,0,0,0));
        vecs.push_back(v(0,0,1,8'hF0,1,0,0,1, 2,8'h00,0,1,0,0,0));
        vecs.push_back(v(0,0,1,8'h00,1,1,0,0, 3,8'h00,0,1,0,0,0));
        vecs.push_back(v(0,0,0,8'h00,0,0,1,0, 3,8'h00,0,0,1,0,0));
        vecs.push_back(v(0,0,1,8'hAA,0,0,0,1, 2,8'h00,0,0,1,1,10'h010));
        vecs.push_back(v(0,0,0,8'h00,0,0,0,1, 1,8'h00,0,0,1,1,10'h2F0));
        vecs.push_back(v(0,0,0,8'h00,0,0,0,1, 0,8'h00,0,0,1,1,10'h300));
        vecs.push_back(v(0,0,0,8'h00,0,0,0,1, 0,8'h00,0,0,1,0,0));
        // overflow: 17 pushes into 16 slots
        vecs.push_back(v(0,1,0,8'h00,0,0,0,0, 0,8'h00,0,1,0,0,0));
        sum = 0;
        for (int i = 1; i <= 17; i++) begin
            if (i <= 16) sum += i;
            vecs.push_back(v(0,0,1,8'(i),0,0,0,0, 5'(i > 16 ? 16 : i),
                             8'(sum), i > 16, 1,0,0,0));
        end
        vecs.push_back(v(0,0,0,8'h00,0,0,1,0, 16,8'h88,1,0,1,0,0));
        for (int j = 1; j <= 16; j++)
            vecs.push_back(v(0,0,0,8'h00,0,0,0,1, 5'(16 - j),8'h88,1,0,1,1,
                             10'(j)));
        // simultaneous valid + done
        vecs.push_back(v(0,1,0,8'h00,0,0,0,0, 0,8'h00,0,1,0,0,0));
        vecs.push_back(v(0,0,1,8'h7E,0,0,1,0, 1,8'h7E,0,0,1,0,0));
        vecs.push_back(v(0,0,0,8'h00,0,0,0,1, 0,8'h7E,0,0,1,1,10'h07E));
        // reset mid-capture
        vecs.push_back(v(0,1,0,8'h00,0,0,0,0, 0,8'h00,0,1,0,0,0));
        sum = 0;
        for (int i = 1; i <= 5; i++) begin
            sum += i;
            vecs.push_back(v(0,0,1,8'(i),0,0,0,0, 5'(i),8'(sum),0,1,0,0,0));
        end
        vecs.push_back(v(1,0,0,8'h00,0,0,0,0, 0,8'h00,0,0,0,0,0));
        vecs.push_back(v(0,0,0,8'h00,0,0,0,1, 0,8'h00,0,0,0,0,0));
        // re-arm in DONE with entries left, arm beats read
        vecs.push_back(v(0,1,0,8'h00,0,0,0,0, 0,8'h00,0,1,0,0,0));
        vecs.push_back(v(0,0,1,8'h10,0,0,0,0, 1,8'h10,0,1,0,0,0));
        vecs.push_back(v(0,0,1,8'hF0,1,0,0,0, 2,8'h00,0,1,0,0,0));
        vecs.push_back(v(0,0,1,8'h00,1,1,1,0, 3,8'h00,0,0,1,0,0));
        vecs.push_back(v(0,0,0,8'h00,0,0,0,1, 2,8'h00,0,0,1,1,10'h010));
        vecs.push_back(v(0,1,0,8'h00,0,0,0,1, 0,8'h00,0,1,0,0,0));
        // arm in CAPTURE with a valid result: it becomes entry 0
        vecs.push_back(v(0,0,1,8'h21,0,0,0,0, 1,8'h21,0,1,0,0,0));
        vecs.push_back(v(0,1,1,8'h33,0,1,0,0, 1,8'h33,0,1,0,0,0));
        vecs.push_back(v(0,0,0,8'h00,0,0,1,0, 1,8'h33,0,0,1,0,0));
        vecs.push_back(v(0,0,0,8'h00,0,0,0,1, 0,8'h33,0,0,1,1,10'h133));

        foreach (vecs[k]) begin
            vec_t t;
            t = vecs[k];
            drive(t.rst, t.arm, t.vld, t.res, t.c, t.z, t.dn, t.rd);
            chk("count", k, o_count, t.cnt);
            chk("checksum", k, o_checksum, t.cks);
            chk("overflow", k, o_overflow, t.ovf);
            chk("capturing", k, o_capturing, t.cap);
            chk("done", k, o_done, t.dne);
            chk("rd_valid", k, o_rd_valid, t.rv);
            if (t.rv)
                chk("rd_data", k, o_rd_data, t.rdat);
        end

        // randomized traffic against the model
        model_step(1,0,0,0,0,0,0,0);
        drive(1,0,0,8'h00,0,0,0,0);
        for (int n = 0; n < 3000; n++) begin
            logic rst, arm, vld, c, z, dn, rd;
            logic [7:0] res;
            rst = ($urandom_range(199) == 0);
            arm = ($urandom_range(39) == 0);
            vld = $urandom_range(1);
            res = 8'($urandom);
            c   = $urandom_range(1);
            z   = $urandom_range(1);
            dn  = ($urandom_range(19) == 0);
            rd  = $urandom_range(1);
            model_step(rst, arm, vld, res, c, z, dn, rd);
            drive(rst, arm, vld, res, c, z, dn, rd);
            chk("r_count", n, o_count, m_q.size());
            chk("r_checksum", n, o_checksum, m_cks);
            chk("r_overflow", n, o_overflow, m_ovf);
            chk("r_capturing", n, o_capturing, m_cap);
            chk("r_done", n, o_done, m_dne);
            chk("r_rd_valid", n, o_rd_valid, m_rv);
            chk("r_rd_data", n, o_rd_data, m_rdat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mest_result_collector.md
Name: mest_result_collector

Overview:
- Consumes the result stream of mest_pro: o_result, o_valid_result, o_carry, o_zero_flag and o_all_done.
- Captures each valid result with its flags into an on-chip buffer, keeps a running checksum and count, and latches completion.
- Gives a host (bench STIM or board controller) a registered read port to drain captured results after the program ends.
- Is the result-side counterpart of the start/reset stimulus that drives mest_pro.

Parameters:
- DATA_WIDTH, 8, width of processor result.
- DEPTH, 16, number of capture entries (power of 2, >= 2).
- CNT_WIDTH, $clog2(DEPTH+1), width of entry count.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_arm  in  1  pulse: clear buffer and start a capture session.
- i_result  in  DATA_WIDTH  processor result.
- i_valid_result  in  1  i_result/flags valid this cycle.
- i_carry  in  1  processor carry flag.
- i_zero_flag  in  1  processor zero flag.
- i_all_done  in  1  processor program finished.
- i_rd_en  in  1  host read request.
- o_rd_valid  out  1  o_rd_data valid (one-cycle pulse).
- o_rd_data  out  DATA_WIDTH+2  {carry, zero, result} of the entry read.
- o_count  out  CNT_WIDTH  entries currently held.
- o_checksum  out  DATA_WIDTH  sum of accepted results, mod 2^DATA_WIDTH.
- o_overflow  out  1  sticky: a valid result was dropped because the buffer was full.
- o_capturing  out  1  state == CAPTURE.
- o_done  out  1  state == DONE.

Behaviour:
- Reset (i_reset=1 at a clk edge) has priority over every other input:
  - state goes to IDLE.
  - wr_ptr, rd_ptr, o_count, o_checksum and o_overflow all reset to 0.
  - o_rd_valid and o_rd_data reset to 0.
  - A reset mid-capture or mid-drain discards all data.
- IDLE state:
  - Ignores i_valid_result, i_all_done and i_rd_en.
  - i_arm moves to CAPTURE and clears pointers, count, checksum and overflow in the same edge.
- CAPTURE state, when i_valid_result=1:
  - If o_count < DEPTH: write {i_carry, i_zero_flag, i_result} at wr_ptr, wr_ptr++ (wraps mod DEPTH), o_count++, o_checksum += i_result.
  - If the buffer is full: drop the entry and set o_overflow. Count and checksum are unchanged.
- CAPTURE state, other events:
  - i_all_done=1 moves to DONE. If i_valid_result is also 1 in that cycle, that entry is captured first, in the same edge.
  - i_arm in CAPTURE restarts: pointers, count, checksum and overflow are cleared, and the state stays CAPTURE. If i_valid_result is also 1 in that cycle, that entry becomes the first entry (count=1).
  - i_rd_en is ignored.
- DONE state:
  - i_valid_result is ignored.
  - i_rd_en with o_count > 0: the next cycle gives o_rd_valid=1 and o_rd_data = mem[rd_ptr]. rd_ptr++ (wrap) and o_count-- take effect at the same edge.
  - Read latency is 1 cycle. Back-to-back reads give one entry per cycle.
  - i_rd_en with o_count == 0 is ignored (o_rd_valid=0).
  - o_checksum holds its value while draining.
  - i_arm returns to CAPTURE with a full clear, even if entries remain.
  - If i_arm and i_rd_en arrive together, i_arm wins and no read is issued.
- Outputs:
  - o_rd_data holds its last value when o_rd_valid=0.
  - o_capturing and o_done are decoded from registered state, with no combinational path from inputs.
- i_all_done seen in IDLE is ignored.

Decomposition:
- Shared package mest_pkg holds:
  - enum collector_state_t {IDLE, CAPTURE, DONE}.
  - packed struct result_entry_t {carry, zero, result[DATA_WIDTH-1:0]}.
  - localparams for the default DATA_WIDTH and DEPTH.
- Sub-module mest_result_fifo holds:
  - the storage array, wr_ptr/rd_ptr and count.
  - synchronous write and a registered read.
  - a clear input.
- The top module holds the FSM, the checksum, the overflow flag and the accept/drop gating.

Test Plan:
- Reset then idle: assert i_reset 2 cycles, pulse i_valid_result with 0x55 -> o_count=0, o_checksum=0x00, o_done=0, o_capturing=0.
- Basic capture/drain: arm; push 0x10 (c=0,z=0), 0xF0 (c=1,z=0), 0x00 (c=1,z=1); assert i_all_done -> o_count=3, o_checksum=0x00 (0x10+0xF0 wraps).
  - Then 3 back-to-back reads -> o_rd_data = 0x010, 0x2F0, 0x300 on consecutive cycles; o_count=0.
  - A fourth read -> o_rd_valid stays 0.
- Overflow: arm; push 17 results 0x01..0x11; assert done -> o_count=16, o_overflow=1, o_checksum=0x88.
  - Drain -> the 16th read returns result 0x10.
- Simultaneous valid+done: arm; single cycle with i_valid_result=1, i_result=0x7E, i_all_done=1 -> o_done=1, o_count=1, o_checksum=0x7E.
  - Then a read -> 0x07E.
- Reset mid-operation: arm; push 5 results; assert i_reset 1 cycle -> state IDLE, o_count=0, o_checksum=0, o_overflow=0.
  - Then i_rd_en -> no o_rd_valid.
- Re-arm in DONE: after the basic scenario with 2 entries unread, pulse i_arm together with i_rd_en -> o_capturing=1, o_count=0, no o_rd_valid.
